// File: rtl/if_stage_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_stage_fetch_unit
// Instruction-fetch stage: holds the PC and reads instruction memory over a
// READ/BUSYWAIT handshake. It buffers one fetched {PC, instruction} pair for the
// IF/ID register.
//
// Ports
//   i_clk, i_reset       clock and synchronous active-high reset
//   i_stall              downstream hold; the buffered instruction is not consumed
//   i_branch_taken       redirect request, sampled at posedge
//   i_branch_target      redirect address; bits [1:0] are forced to 0
//   o_imem_read_c        memory read request (decoded from state, gated by reset)
//   o_imem_address_c     word-aligned read address (current PC)
//   i_imem_readdata      read data, valid when i_imem_busywait=0 during a read
//   i_imem_busywait      1 = memory access in progress
//   o_pc                 PC of the buffered instruction
//   o_instruction        buffered instruction, or NOP_INSTR when empty
//   o_valid              1 = o_pc/o_instruction hold a real instruction
//   o_busywait_c         to IF/ID: i_stall | ~o_valid
// -----------------------------------------------------------------------------
module if_stage_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   output logic        o_imem_read_c,
   output logic [31:0] o_imem_address_c,
   input  logic [31:0] i_imem_readdata,
   input  logic        i_imem_busywait,
   output logic [31:0] o_pc,
   output logic [31:0] o_instruction,
   output logic        o_valid,
   output logic        o_busywait_c
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_FULL  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_out_pc;
   logic [31:0] r_out_instr;
   logic        r_out_valid;
   logic [31:0] r_redirect;

   logic [1:0]  w_state_nxt;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_out_pc_nxt;
   logic [31:0] w_out_instr_nxt;
   logic        w_out_valid_nxt;
   logic [31:0] w_redirect_nxt;
   logic [31:0] w_target;

   assign w_target = i_branch_target & 32'hFFFF_FFFC;

   // State and datapath registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_FETCH;
         r_pc        <= RESET_PC;
         r_out_pc    <= 32'h0000_0000;
         r_out_instr <= NOP_INSTR;
         r_out_valid <= 1'b0;
         r_redirect  <= 32'h0000_0000;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_out_pc    <= w_out_pc_nxt;
         r_out_instr <= w_out_instr_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_redirect  <= w_redirect_nxt;
      end
   end

   // Next-state and datapath update; a redirect overrides completion and stall
   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_out_pc_nxt    = r_out_pc;
      w_out_instr_nxt = r_out_instr;
      w_out_valid_nxt = r_out_valid;
      w_redirect_nxt  = r_redirect;

      if (i_branch_taken) begin
         w_out_valid_nxt = 1'b0;
         w_out_instr_nxt = NOP_INSTR;
         // An in-flight access cannot be dropped: remember the target until it ends
         if (((r_state == S_FETCH) || (r_state == S_FLUSH)) && i_imem_busywait) begin
            w_redirect_nxt = w_target;
            w_state_nxt    = S_FLUSH;
         end else begin
            w_pc_nxt    = w_target;
            w_state_nxt = S_FETCH;
         end
      end else begin
         case (r_state)
            S_FETCH: begin
               if (!i_imem_busywait) begin
                  w_out_instr_nxt = i_imem_readdata;
                  w_out_pc_nxt    = r_pc;
                  w_out_valid_nxt = 1'b1;
                  w_pc_nxt        = r_pc + 32'd4;
                  w_state_nxt     = S_FULL;
               end
            end
            S_FULL: begin
               if (!i_stall) begin
                  w_out_valid_nxt = 1'b0;
                  w_out_instr_nxt = NOP_INSTR;
                  w_state_nxt     = S_FETCH;
               end
            end
            S_FLUSH: begin
               // Stale data is discarded, fetch resumes at the latched target
               if (!i_imem_busywait) begin
                  w_pc_nxt    = r_redirect;
                  w_state_nxt = S_FETCH;
               end
            end
            default: w_state_nxt = S_FETCH;
         endcase
      end
   end

   // Memory request follows state only; reset aborts it in the same cycle
   assign o_imem_read_c    = ~i_reset & ((r_state == S_FETCH) || (r_state == S_FLUSH));
   assign o_imem_address_c = r_pc;

   assign o_pc          = r_out_pc;
   assign o_instruction = r_out_instr;
   assign o_valid       = r_out_valid;
   assign o_busywait_c  = i_stall | ~r_out_valid;

endmodule

// File: tb/tb_if_stage_fetch_unit.sv
module tb_if_stage_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset, stall, branch_taken, imem_busywait;
   logic [31:0] branch_target;

   logic        imem_read, imem_read2;
   logic [31:0] imem_addr, imem_addr2, imem_rdata, imem_rdata2;
   logic [31:0] out_pc, out_pc2, out_instr, out_instr2;
   logic        out_valid, out_valid2, busywait, busywait2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_data(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   // Instruction memory model: data is a fixed function of the address
   always_comb imem_rdata  = imem_data(imem_addr);
   always_comb imem_rdata2 = imem_data(imem_addr2);

   if_stage_fetch_unit u_dut (
      .i_clk(clk), .i_reset(reset), .i_stall(stall),
      .i_branch_taken(branch_taken), .i_branch_target(branch_target),
      .o_imem_read_c(imem_read), .o_imem_address_c(imem_addr),
      .i_imem_readdata(imem_rdata), .i_imem_busywait(imem_busywait),
      .o_pc(out_pc), .o_instruction(out_instr), .o_valid(out_valid),
      .o_busywait_c(busywait)
   );

   if_stage_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
      .i_clk(clk), .i_reset(reset), .i_stall(stall),
      .i_branch_taken(branch_taken), .i_branch_target(branch_target),
      .o_imem_read_c(imem_read2), .o_imem_address_c(imem_addr2),
      .i_imem_readdata(imem_rdata2), .i_imem_busywait(imem_busywait),
      .o_pc(out_pc2), .o_instruction(out_instr2), .o_valid(out_valid2),
      .o_busywait_c(busywait2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pop the scoreboard and compare with the buffered instruction
   task automatic expect_out(input string tag);
      exp_t e;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_pc"}, out_pc, e.pc);
         chk({tag, "_instr"}, out_instr, e.instr);
      end
   endtask

   task automatic push(input logic [31:0] pc);
      exp_t e;
      e.pc    = pc;
      e.instr = imem_data(pc);
      exp_q.push_back(e);
   endtask

   // Advance one cycle; inputs change 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
      branch_target = 32'h0; imem_busywait = 1'b0;

      // Reset state
      tick(); tick();
      #1;
      chk("rst_read",  32'(imem_read), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_pc",    out_pc, 32'h0);
      chk("rst_instr", out_instr, NOP);
      reset = 1'b0;
      #1;
      chk("rel_read", 32'(imem_read), 32'd1);
      chk("rel_addr", imem_addr, 32'h0);
      chk("rel_busy", 32'(busywait), 32'd1);

      // Back-to-back fetches with a single-cycle memory
      for (int i = 0; i < 2; i++) begin
         push(32'(i * 4));
         tick();
         expect_out("seq");
         chk("seq_busy_full", 32'(busywait), 32'd0);
         chk("seq_read_full", 32'(imem_read), 32'd0);
         tick();
         chk("seq_valid_fetch", 32'(out_valid), 32'd0);
         chk("seq_addr", imem_addr, 32'((i + 1) * 4));
         chk("seq_busy_fetch", 32'(busywait), 32'd1);
      end

      // Memory wait states at 0x8
      imem_busywait = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("wait_read", 32'(imem_read), 32'd1);
         chk("wait_addr", imem_addr, 32'h8);
         chk("wait_valid", 32'(out_valid), 32'd0);
         chk("wait_busy", 32'(busywait), 32'd1);
      end
      imem_busywait = 1'b0;
      push(32'h8);
      tick();
      expect_out("wait_cap");

      // Stall holds the buffered instruction
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_pc", out_pc, 32'h8);
         chk("stall_instr", out_instr, imem_data(32'h8));
         chk("stall_read", 32'(imem_read), 32'd0);
         chk("stall_busy", 32'(busywait), 32'd1);
      end
      stall = 1'b0;
      tick();
      chk("unstall_valid", 32'(out_valid), 32'd0);
      chk("unstall_read", 32'(imem_read), 32'd1);
      chk("unstall_addr", imem_addr, 32'hC);

      // Redirect from FULL, target low bits ignored
      push(32'hC);
      tick();
      expect_out("pre_br");
      branch_taken = 1'b1; branch_target = 32'h103;
      tick();
      branch_taken = 1'b0;
      chk("br_full_valid", 32'(out_valid), 32'd0);
      chk("br_full_instr", out_instr, NOP);
      chk("br_full_addr", imem_addr, 32'h100);
      push(32'h100);
      tick();
      expect_out("br_full_tgt");
      tick();
      chk("br_full_next", imem_addr, 32'h104);

      // Redirect during a busy fetch: in-flight access must finish first
      imem_busywait = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
      tick();
      branch_taken = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("flush_read", 32'(imem_read), 32'd1);
         chk("flush_addr", imem_addr, 32'h104);
         chk("flush_valid", 32'(out_valid), 32'd0);
         tick();
      end
      imem_busywait = 1'b0;
      tick();
      chk("flush_drop_valid", 32'(out_valid), 32'd0);
      chk("flush_new_addr", imem_addr, 32'h200);
      push(32'h200);
      tick();
      expect_out("flush_tgt");
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      // PC wrap and reset during an access (second instance, RESET_PC=0xFFFFFFFC)
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
      tick();
      chk("wrap_valid", 32'(out_valid2), 32'd1);
      chk("wrap_pc", out_pc2, 32'hFFFF_FFFC);
      chk("wrap_instr", out_instr2, imem_data(32'hFFFF_FFFC));
      tick();
      chk("wrap_next_addr", imem_addr2, 32'h0);
      imem_busywait = 1'b1;
      tick();
      chk("midrst_pre_read", 32'(imem_read2), 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_read", 32'(imem_read2), 32'd0);
      tick();
      chk("midrst_valid", 32'(out_valid2), 32'd0);
      chk("midrst_read_held", 32'(imem_read2), 32'd0);
      reset = 1'b0; imem_busywait = 1'b0;
      #1;
      chk("midrst_rel_read", 32'(imem_read2), 32'd1);
      chk("midrst_rel_addr", imem_addr2, 32'hFFFF_FFFC);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
